// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer.
// Samples the PC, issues a memory read, waits for mem_ready, latches the
// returned word into ir, pulses pc_en with the incremented address, and holds
// the instruction until decode acknowledges it. A watchdog raises a sticky
// fault if memory does not answer within TIMEOUT wait cycles.
//
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   pc_q                  current PC value
//   fetch_req, flush      fetch request / abort outstanding fetch
//   ir_ack                decode consumed ir
//   fault_clr             clears the sticky fault
//   mem_rdata, mem_ready  memory read data and its valid strobe
//   mem_addr, mem_rd      registered read address and read strobe
//   ir, ir_valid          instruction register and its valid flag
//   pc_en, next_pc        one-cycle PC load enable and the value to load
//   busy, fault           not-idle indicator and sticky timeout flag
module ifetch_unit #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_q,
  input  logic              fetch_req,
  input  logic              flush,
  input  logic              ir_ack,
  input  logic              fault_clr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              pc_en,
  output logic [ADDR_W-1:0] next_pc,
  output logic              busy,
  output logic              fault
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              pc_en_q, pc_en_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      pc_en_q    <= 1'b0;
      next_pc_q  <= '0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_en_q    <= pc_en_d;
      next_pc_q  <= next_pc_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_en_d    = 1'b0;
    next_pc_d  = next_pc_q;
    fault_d    = fault_q;

    case (state_q)
      S_IDLE: begin
        if (fetch_req) begin
          mem_addr_d = pc_q;
          mem_rd_d   = 1'b1;
          cnt_d      = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // Flush beats ready, and ready beats the watchdog.
        if (flush) begin
          mem_rd_d = 1'b0;
          state_d  = S_IDLE;
        end else if (mem_ready) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          pc_en_d    = 1'b1;
          next_pc_d  = ADDR_W'(mem_addr_q + ADDR_W'(1));
          mem_rd_d   = 1'b0;
          state_d    = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d  = 1'b1;
          mem_rd_d = 1'b0;
          state_d  = S_FAULT;
        end else begin
          cnt_d = CNT_W'(cnt_q + CNT_W'(1));
        end
      end
      S_DONE: begin
        if (ir_ack || flush) begin
          ir_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_FAULT: begin
        if (fault_clr) begin
          fault_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc_en    = pc_en_q;
  assign next_pc  = next_pc_q;
  assign busy     = busy_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a scoreboard of expected fetch results.
module tb_ifetch_unit;

  logic        clk;
  logic        reset;
  logic [15:0] pc_q;
  logic        fetch_req;
  logic        flush;
  logic        ir_ack;
  logic        fault_clr;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] ir;
  logic        ir_valid;
  logic        pc_en;
  logic [15:0] next_pc;
  logic        busy;
  logic        fault;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
  } exp_t;

  exp_t sb[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   pc_en_cnt = 0;
  logic prev_pc_en = 1'b0;

  ifetch_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_q     (pc_q),
    .fetch_req(fetch_req),
    .flush    (flush),
    .ir_ack   (ir_ack),
    .fault_clr(fault_clr),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .ir       (ir),
    .ir_valid (ir_valid),
    .pc_en    (pc_en),
    .next_pc  (next_pc),
    .busy     (busy),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every pc_en pulse must be a single cycle and match the oldest pending fetch.
  always @(negedge clk) begin
    if (pc_en) begin
      exp_t e;
      pc_en_cnt++;
      chk("pc_en_width", 32'(prev_pc_en), 32'd0);
      chk("pc_en_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_ir", 32'(ir), 32'(e.ir));
        chk("sb_next_pc", 32'(next_pc), 32'(e.npc));
      end
    end
    prev_pc_en = pc_en;
  end

  // Fetch from addr, memory answers with data after 'waits' extra WAIT cycles.
  task automatic do_fetch(input logic [15:0] addr, input logic [15:0] data, input int waits);
    exp_t e;
    pc_q      = addr;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    chk("req_mem_rd", 32'(mem_rd), 32'd1);
    chk("req_mem_addr", 32'(mem_addr), 32'(addr));
    chk("req_busy", 32'(busy), 32'd1);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("wait_mem_rd", 32'(mem_rd), 32'd1);
      chk("wait_mem_addr", 32'(mem_addr), 32'(addr));
    end
    mem_ready = 1'b1;
    mem_rdata = data;
    e.ir  = data;
    e.npc = addr + 16'd1;
    sb.push_back(e);
    tick();
    mem_ready = 1'b0;
    chk("done_ir", 32'(ir), 32'(data));
    chk("done_ir_valid", 32'(ir_valid), 32'd1);
    chk("done_pc_en", 32'(pc_en), 32'd1);
    chk("done_next_pc", 32'(next_pc), 32'(e.npc));
    chk("done_mem_rd", 32'(mem_rd), 32'd0);
  endtask

  task automatic do_ack();
    tick();
    chk("ack_pc_en_low", 32'(pc_en), 32'd0);
    chk("ack_ir_valid_held", 32'(ir_valid), 32'd1);
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    chk("ack_ir_valid", 32'(ir_valid), 32'd0);
    chk("ack_busy", 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_ir"}, 32'(ir), 32'd0);
    chk({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
    chk({tag, "_pc_en"}, 32'(pc_en), 32'd0);
    chk({tag, "_next_pc"}, 32'(next_pc), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset     = 1'b0;
    pc_q      = '0;
    fetch_req = 1'b0;
    flush     = 1'b0;
    ir_ack    = 1'b0;
    fault_clr = 1'b0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    #2;
    chk_all_zero("reset");
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Zero-wait fetch with ack.
    do_fetch(16'h0010, 16'hA5C3, 0);
    do_ack();

    // Wrap of next_pc with three wait cycles.
    do_fetch(16'hFFFF, 16'h1234, 3);
    do_ack();

    // Watchdog: memory never answers; fetch_req held high is ignored.
    pc_q      = 16'h0200;
    fetch_req = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("to_no_fault", 32'(fault), 32'd0);
      chk("to_mem_rd", 32'(mem_rd), 32'd1);
      tick();
    end
    chk("to_last_wait_fault", 32'(fault), 32'd0);
    tick();
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_mem_rd_low", 32'(mem_rd), 32'd0);
    chk("to_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    tick();
    flush     = 1'b0;
    fetch_req = 1'b0;
    chk("to_fault_sticky", 32'(fault), 32'd1);
    chk("to_ignore_req", 32'(mem_rd), 32'd0);
    chk("to_ir_kept", 32'(ir), 32'h1234);
    chk("to_ir_valid_kept", 32'(ir_valid), 32'd0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    do_fetch(16'h0201, 16'h5A5A, 1);
    do_ack();

    // Flush and ready in the same WAIT cycle: flush wins.
    pc_q      = 16'h0300;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    flush     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    flush     = 1'b0;
    mem_ready = 1'b0;
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_mem_rd", 32'(mem_rd), 32'd0);
    chk("fl_ir", 32'(ir), 32'h5A5A);
    chk("fl_ir_valid", 32'(ir_valid), 32'd0);
    chk("fl_next_pc", 32'(next_pc), 32'h0202);
    chk("fl_pc_en", 32'(pc_en), 32'd0);
    tick();

    // Ready on the last watchdog cycle: ready wins.
    do_fetch(16'h0400, 16'h0F0F, 15);
    chk("edge_no_fault", 32'(fault), 32'd0);
    do_ack();

    // Asynchronous reset mid-WAIT.
    pc_q      = 16'h0600;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    chk("ar_pre_mem_rd", 32'(mem_rd), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    reset = 1'b1;
    tick();

    // Back-to-back fetches with fetch_req held, ack two cycles after ir_valid.
    pc_q      = 16'h0500;
    fetch_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      tick();
      chk("b2b_mem_addr", 32'(mem_addr), 32'(pc_q));
      chk("b2b_mem_rd", 32'(mem_rd), 32'd1);
      mem_ready = 1'b1;
      mem_rdata = 16'h1000 + 16'(k);
      e.ir  = mem_rdata;
      e.npc = pc_q + 16'd1;
      sb.push_back(e);
      tick();
      mem_ready = 1'b0;
      chk("b2b_pc_en", 32'(pc_en), 32'd1);
      chk("b2b_ir_valid", 32'(ir_valid), 32'd1);
      pc_q = e.npc;
      tick();
      chk("b2b_done_no_rd", 32'(mem_rd), 32'd0);
      chk("b2b_done_busy", 32'(busy), 32'd1);
      ir_ack = 1'b1;
      tick();
      ir_ack = 1'b0;
      chk("b2b_bubble_ir_valid", 32'(ir_valid), 32'd0);
      chk("b2b_bubble_busy", 32'(busy), 32'd0);
      chk("b2b_bubble_mem_rd", 32'(mem_rd), 32'd0);
    end
    fetch_req = 1'b0;
    tick();
    tick();

    chk("pc_en_total", 32'(pc_en_cnt), 32'd7);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
